// File: rtl/button_input_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// button_input_ctrl_pkg
// Shared types and constants for the board button conditioning path.
// dir_t is also consumed by drawing_logic, so its encoding must stay fixed:
// DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
// Contents:
//   dir_t                 - direction handed to the game logic
//   pend_state_t          - request holding state inside button_input_ctrl
//   BTN_U/BTN_D/BTN_L/BTN_R - bit index of each button in the 4-bit vectors
//   *_DEFAULT             - default timing parameters for a 25 MHz pixel clock
//   press_winner()        - fixed-priority pick among simultaneous presses
// ---------------------------------------------------------------------------
package button_input_ctrl_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } pend_state_t;

   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;

   // 10 ms of stable input at 25 MHz before a level is accepted
   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
   localparam int SYNC_STAGES_DEFAULT     = 2;
   localparam int REPEAT_FRAMES_DEFAULT   = 8;

   // Up beats down beats left beats right when several presses land together.
   // Callers only use the result when at least one press bit is set.
   function automatic dir_t press_winner(input logic [3:0] press);
      dir_t w;
      if (press[BTN_U])
         w = DIR_UP;
      else if (press[BTN_D])
         w = DIR_DOWN;
      else if (press[BTN_L])
         w = DIR_LEFT;
      else
         w = DIR_RIGHT;
      return w;
   endfunction

endpackage

// File: rtl/button_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// button_input_ctrl_if
// Bundles the frame strobe, raw buttons and all conditioned outputs of
// button_input_ctrl.
//   frame_stb  - one-cycle start-of-frame strobe
//   btn_raw    - asynchronous buttons, [0]=U [1]=D [2]=L [3]=R
//   btn_level  - debounced level per button
//   btn_press  - one-cycle pulse per debounced press
//   dir        - direction handed over at the last frame strobe
//   dir_valid  - one-cycle pulse the cycle after a handover
//   pending    - a request is held and not yet handed over
// Modports: master drives strobe/buttons (board side), slave is the
// conditioning block itself.
// ---------------------------------------------------------------------------
interface button_input_ctrl_if;
   import button_input_ctrl_pkg::*;

   logic       frame_stb;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   dir_t       dir;
   logic       dir_valid;
   logic       pending;

   modport master (
      output frame_stb,
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  dir,
      input  dir_valid,
      input  pending
   );

   modport slave (
      input  frame_stb,
      input  btn_raw,
      output btn_level,
      output btn_press,
      output dir,
      output dir_valid,
      output pending
   );

endinterface

// File: rtl/button_input_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button: SYNC_STAGES-deep synchronizer, counter-based debounce and
// registered rising-edge detect.
// Ports:
//   vga_pix_clk - pixel clock, all logic on its rising edge
//   rst_n       - synchronous active-low reset
//   raw         - asynchronous button input
//   level       - debounced stable level
//   press       - one-cycle pulse one cycle after level rises
// Parameters:
//   DEBOUNCE_CYCLES - cycles the synchronized input must differ before the
//                     stable level flips (must be >= 2)
//   SYNC_STAGES     - synchronizer depth, 2..4
// ---------------------------------------------------------------------------
module btn_debounce
   import button_input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic vga_pix_clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_bit;
   logic [CW-1:0]          cnt;
   logic                   level_q;

   assign sync_bit = sync_ff[SYNC_STAGES-1];

   // Shift chain bringing the asynchronous button into the pixel clock
   // domain; only the last stage is ever looked at.
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n)
         sync_ff <= '0;
      else
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
   end

   // The counter measures how long the synchronized input has disagreed with
   // the accepted level. Any agreement restarts it, so a bounce shorter than
   // DEBOUNCE_CYCLES never flips the level. It is cleared on the flip itself,
   // which is why it can never run past CNT_LAST and wrap.
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_bit == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         level <= ~level;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Registered rising-edge detect: the press pulse appears the cycle after
   // the level rises and lasts exactly one cycle; releases produce nothing.
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/button_input_ctrl.sv
// ---------------------------------------------------------------------------
// button_input_ctrl
// Conditions the four board buttons for drawing_logic: each button is
// synchronized, debounced and edge-detected (btn_debounce x4), presses are
// arbitrated into one pending direction, and that direction is handed over
// once per frame on frame_stb.
// Ports:
//   vga_pix_clk - pixel clock, all logic on its rising edge
//   rst_n       - synchronous active-low reset
//   bus         - button_input_ctrl_if.slave (frame_stb, btn_raw in;
//                 btn_level, btn_press, dir, dir_valid, pending out)
// Optional build macro:
//   BTN_AUTOREPEAT_EN - when defined, a held button re-injects a press every
//                       REPEAT_FRAMES frame strobes; when undefined a held
//                       button gives exactly one press.
// ---------------------------------------------------------------------------
module button_input_ctrl
   import button_input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int REPEAT_FRAMES   = REPEAT_FRAMES_DEFAULT
) (
   input  logic vga_pix_clk,
   input  logic rst_n,
   button_input_ctrl_if.slave bus
);

   logic [3:0]  deb_level;
   logic [3:0]  deb_press;
   logic [3:0]  rep_press;
   logic [3:0]  press_all;
   logic        any_press;
   dir_t        win_dir;

   pend_state_t state;
   pend_state_t state_nxt;
   logic        handover;

   dir_t        pending_dir;
   dir_t        dir_q;
   logic        dir_valid_q;

   // One conditioning slice per button
   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_btn_debounce (
         .vga_pix_clk (vga_pix_clk),
         .rst_n       (rst_n),
         .raw         (bus.btn_raw[i]),
         .level       (deb_level[i]),
         .press       (deb_press[i])
      );
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RCW = $clog2(REPEAT_FRAMES + 1);
   localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_FRAMES - 1);

   logic [RCW-1:0] rep_cnt [4];

   // Auto-repeat: while a button is held, count frame strobes and inject a
   // press the cycle after every REPEAT_FRAMES-th one. Releasing the button
   // restarts the count so the next hold waits a full repeat period.
   always_ff @(posedge vga_pix_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!rst_n || !deb_level[i]) begin
            rep_cnt[i]   <= '0;
            rep_press[i] <= 1'b0;
         end else if (bus.frame_stb && (rep_cnt[i] == REP_LAST)) begin
            rep_cnt[i]   <= '0;
            rep_press[i] <= 1'b1;
         end else if (bus.frame_stb) begin
            rep_cnt[i]   <= rep_cnt[i] + RCW'(1);
            rep_press[i] <= 1'b0;
         end else begin
            rep_press[i] <= 1'b0;
         end
      end
   end
`else
   logic unused_repeat_cfg;

   assign rep_press         = '0;
   assign unused_repeat_cfg = ^REPEAT_FRAMES;
`endif

   assign press_all = deb_press | rep_press;
   assign any_press = |press_all;
   assign win_dir   = press_winner(press_all);

   // Request state register
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // A frame strobe hands over whenever there is something to hand over,
   // either a held request or a press landing in the strobe cycle itself.
   // A press outside a strobe cycle (re)arms the pending request.
   always_comb begin
      state_nxt = state;
      handover  = 1'b0;
      if (bus.frame_stb && ((state == ST_PENDING) || any_press)) begin
         handover  = 1'b1;
         state_nxt = ST_IDLE;
      end else if (any_press) begin
         state_nxt = ST_PENDING;
      end
   end

   // Direction datapath: the most recent press always overwrites the held
   // direction, and a press in the strobe cycle bypasses the held value so
   // the game sees it this frame rather than the next.
   always_ff @(posedge vga_pix_clk) begin
      if (!rst_n) begin
         pending_dir <= DIR_RIGHT;
         dir_q       <= DIR_RIGHT;
         dir_valid_q <= 1'b0;
      end else begin
         dir_valid_q <= handover;
         if (any_press)
            pending_dir <= win_dir;
         if (handover)
            dir_q <= any_press ? win_dir : pending_dir;
      end
   end

   assign bus.btn_level = deb_level;
   assign bus.btn_press = press_all;
   assign bus.dir       = dir_q;
   assign bus.dir_valid = dir_valid_q;
   assign bus.pending   = (state == ST_PENDING);

endmodule

// File: tb/tb_button_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_input_ctrl
// Directed bench for button_input_ctrl with short timing parameters
// (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_FRAMES=2). A behavioural model
// tracks what every output must be from the button rules and is compared
// with the DUT each cycle; directed steps add literal expectations.
// Honours BTN_AUTOREPEAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_button_input_ctrl;
   import button_input_ctrl_pkg::*;

   localparam int DEB = 4;
   localparam int SYN = 2;
   localparam int REP = 2;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   logic cmp_en;
   logic cnt_en;
   int   press_cnt;
   logic [3:0] cur_raw;

   button_input_ctrl_if bus();

   button_input_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYN),
      .REPEAT_FRAMES   (REP)
   ) dut (
      .vga_pix_clk (clk),
      .rst_n       (rst_n),
      .bus         (bus)
   );

   // 10 ns pixel clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic [3:0] raw, input logic fs, input logic rn);
      cur_raw       = raw;
      bus.btn_raw   = raw;
      bus.frame_stb = fs;
      rst_n         = rn;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseFrame();
      applyStimulus(cur_raw, 1'b1, 1'b1);
      step(1);
      applyStimulus(cur_raw, 1'b0, 1'b1);
   endtask

   // Behavioural model: delay line for the synchronizer, run-length count of
   // disagreement for the debounce, and plain request bookkeeping.
   logic [3:0] m_hist [SYN];
   int         m_run [4];
   int         m_frames [4];
   logic [3:0] m_level, m_level_d, m_press;
   logic [1:0] m_dir, m_pdir;
   logic       m_valid, m_pend;

   always @(posedge clk) begin
      logic [3:0] sync_now, lvl_new, prs_new;
      logic       hand;
      logic [1:0] w;
      if (!rst_n) begin
         for (int k = 0; k < SYN; k++) m_hist[k] = '0;
         for (int i = 0; i < 4; i++) begin
            m_run[i]    = 0;
            m_frames[i] = 0;
         end
         m_level = '0; m_level_d = '0; m_press = '0;
         m_dir = 2'd3; m_pdir = 2'd3; m_valid = 1'b0; m_pend = 1'b0;
      end else begin
         sync_now = m_hist[SYN-1];
         for (int k = SYN - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = bus.btn_raw;
         lvl_new = m_level;
         for (int i = 0; i < 4; i++) begin
            if (sync_now[i] == m_level[i])
               m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  lvl_new[i] = ~m_level[i];
                  m_run[i]   = 0;
               end
            end
         end
         prs_new = m_level & ~m_level_d;
`ifdef BTN_AUTOREPEAT_EN
         for (int i = 0; i < 4; i++) begin
            if (!m_level[i])
               m_frames[i] = 0;
            else if (bus.frame_stb) begin
               m_frames[i]++;
               if (m_frames[i] == REP) begin
                  prs_new[i]  = 1'b1;
                  m_frames[i] = 0;
               end
            end
         end
`endif
         w = 2'd0;
         for (int i = 3; i >= 0; i--) if (m_press[i]) w = 2'(i);
         hand    = bus.frame_stb && (m_pend || (m_press != 0));
         m_valid = hand;
         if (hand) begin
            m_dir  = (m_press != 0) ? w : m_pdir;
            m_pend = 1'b0;
         end else if (m_press != 0)
            m_pend = 1'b1;
         if (m_press != 0) m_pdir = w;
         m_level_d = m_level;
         m_level   = lvl_new;
         m_press   = prs_new;
      end
   end

   // Compare DUT against the model on every cycle once reset has been seen
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("model_btn_level", int'(bus.btn_level), int'(m_level));
         checkOutput("model_btn_press", int'(bus.btn_press), int'(m_press));
         checkOutput("model_dir",       int'(bus.dir),       int'(m_dir));
         checkOutput("model_dir_valid", int'(bus.dir_valid), int'(m_valid));
         checkOutput("model_pending",   int'(bus.pending),   int'(m_pend));
      end
   end

   // Counts btn_press[0] pulses inside a measurement window
   always @(negedge clk) begin
      if (cnt_en && bus.btn_press[0]) press_cnt++;
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      cmp_en    = 1'b0;
      cnt_en    = 1'b0;
      press_cnt = 0;
      applyStimulus(4'b1111, 1'b0, 1'b0);
      step(1);
      cmp_en = 1'b1;
      step(2);
      checkOutput("reset_level",   int'(bus.btn_level), 0);
      checkOutput("reset_dir",     int'(bus.dir),       int'(DIR_RIGHT));
      checkOutput("reset_pending", int'(bus.pending),   0);
      checkOutput("reset_valid",   int'(bus.dir_valid), 0);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(4);

      // Three-cycle glitch on U must be rejected
      cnt_en = 1'b1;
      applyStimulus(4'b0001, 1'b0, 1'b1);
      step(3);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);
      cnt_en = 1'b0;
      checkOutput("glitch_level", int'(bus.btn_level), 0);
      checkOutput("glitch_press", press_cnt, 0);

      // Held U: level after 2+4 edges, press one edge later, then pending
      applyStimulus(4'b0001, 1'b0, 1'b1);
      step(5);
      checkOutput("deb_level_early", int'(bus.btn_level[0]), 0);
      step(1);
      checkOutput("deb_level_rise", int'(bus.btn_level[0]), 1);
      checkOutput("deb_press_early", int'(bus.btn_press), 0);
      step(1);
      checkOutput("deb_press", int'(bus.btn_press), 4'b0001);
      step(1);
      checkOutput("deb_pending", int'(bus.pending), 1);
      checkOutput("deb_press_once", int'(bus.btn_press), 0);
      pulseFrame();
      checkOutput("hand_u_dir",   int'(bus.dir),       int'(DIR_UP));
      checkOutput("hand_u_valid", int'(bus.dir_valid), 1);
      checkOutput("hand_u_pend",  int'(bus.pending),   0);
      step(1);
      checkOutput("hand_u_valid_end", int'(bus.dir_valid), 0);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      // L then R: most recent press wins
      applyStimulus(4'b0100, 1'b0, 1'b1);
      step(8);
      applyStimulus(4'b1100, 1'b0, 1'b1);
      step(8);
      checkOutput("lr_pending", int'(bus.pending), 1);
      pulseFrame();
      checkOutput("lr_dir",   int'(bus.dir),       int'(DIR_RIGHT));
      checkOutput("lr_valid", int'(bus.dir_valid), 1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      // D and R together: D has priority
      applyStimulus(4'b1010, 1'b0, 1'b1);
      step(8);
      pulseFrame();
      checkOutput("dr_dir",   int'(bus.dir),       int'(DIR_DOWN));
      checkOutput("dr_valid", int'(bus.dir_valid), 1);
      checkOutput("dr_pend",  int'(bus.pending),   0);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      // Pending U, then L press coincident with frame_stb: L goes out
      applyStimulus(4'b0001, 1'b0, 1'b1);
      step(8);
      applyStimulus(4'b0101, 1'b0, 1'b1);
      step(7);
      checkOutput("same_press", int'(bus.btn_press), 4'b0100);
      pulseFrame();
      checkOutput("same_dir",   int'(bus.dir),       int'(DIR_LEFT));
      checkOutput("same_valid", int'(bus.dir_valid), 1);
      checkOutput("same_pend",  int'(bus.pending),   0);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      // D press one cycle after frame_stb waits for the next frame
      applyStimulus(4'b0010, 1'b0, 1'b1);
      step(6);
      pulseFrame();
      checkOutput("late_valid", int'(bus.dir_valid), 0);
      checkOutput("late_press", int'(bus.btn_press), 4'b0010);
      step(1);
      checkOutput("late_pend", int'(bus.pending), 1);
      checkOutput("late_dir",  int'(bus.dir),     int'(DIR_LEFT));
      pulseFrame();
      checkOutput("late_dir_next", int'(bus.dir), int'(DIR_DOWN));
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      // Frame with nothing pending
      pulseFrame();
      checkOutput("idle_valid", int'(bus.dir_valid), 0);
      checkOutput("idle_dir",   int'(bus.dir),       int'(DIR_DOWN));

      // Reset while a request is pending discards it
      applyStimulus(4'b0001, 1'b0, 1'b1);
      step(8);
      checkOutput("rst_pend_before", int'(bus.pending), 1);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      step(1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("rst_pend_after", int'(bus.pending), 0);
      checkOutput("rst_dir_after",  int'(bus.dir),     int'(DIR_RIGHT));
      step(2);
      pulseFrame();
      checkOutput("rst_frame_valid", int'(bus.dir_valid), 0);

      // Hold U across five frames
      press_cnt = 0;
      cnt_en    = 1'b1;
      applyStimulus(4'b0001, 1'b0, 1'b1);
      step(8);
      for (int f = 0; f < 5; f++) begin
         step(3);
         pulseFrame();
      end
      step(4);
      cnt_en = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      checkOutput("hold_press_count", press_cnt, 3);
`else
      checkOutput("hold_press_count", press_cnt, 1);
`endif
      applyStimulus(4'b0000, 1'b0, 1'b1);
      step(10);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_input_ctrl.md
Name: button_input_ctrl

Overview:
- Conditions the four raw board buttons (BTNU/BTND/BTNL/BTNR) before they reach drawing_logic.
- Each button passes through synchronizer -> debounce -> rising-edge detect.
- Presses are arbitrated into a single pending direction request, which is handed to the game logic once per frame on frame_stb.
- Sits directly upstream of drawing_logic, in the vga_pix_clk domain.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronized input must differ from the stable state before the stable state flips (10 ms at 25 MHz).
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer; legal range 2..4.
- REPEAT_FRAMES, 8: frames between auto-repeat presses (used only with the optional feature).

Ports:
- vga_pix_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- frame_stb  in  1  one-cycle strobe at start of frame (same strobe drawing_logic receives).
- btn_raw  in  4  asynchronous buttons; index [0]=U, [1]=D, [2]=L, [3]=R.
- btn_level  out  4  debounced stable level per button.
- btn_press  out  4  one-cycle pulse on a debounced 0->1 transition.
- dir  out  2  dir_t; direction handed over at the last frame_stb.
- dir_valid  out  1  one-cycle pulse, the cycle after frame_stb, when dir was updated.
- pending  out  1  a request is captured and not yet handed over.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While rst_n=0 on a clock edge, all outputs and state return to their reset values:
  - btn_level=0, btn_press=0, dir=DIR_RIGHT, dir_valid=0, pending=0.
  - Synchronizer flops=0, debounce counters=0.
  - A reset asserted mid-debounce discards the partial count. A reset asserted with a request pending discards the request.
- Synchronizer: SYNC_STAGES flops per bit; raw-to-sync latency is SYNC_STAGES cycles.
- Debounce (per bit):
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync == btn_level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync still differs, btn_level flips that cycle and the counter clears.
  - The counter never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no level change.
- Edge detect: btn_press[i] = btn_level[i] & ~btn_level_q[i], registered, asserted for exactly one cycle. Falling edges produce nothing.
- Arbitration, on any cycle with btn_press != 0:
  - Winner is the lowest set index (U > D > L > R).
  - pending_dir <= winner, pending <= 1.
  - A newer press overwrites an older pending request (most recent wins).
- Handover, on frame_stb=1 with pending=1 (including a press in that same cycle):
  - At the next edge, dir <= the winner of that cycle (if a press is present) else pending_dir.
  - dir_valid <= 1 for one cycle; pending <= 0.
- frame_stb with pending=0 and no press: dir holds, dir_valid=0.
- A press arriving in the cycle after frame_stb becomes pending for the next frame.
- dir holds its value indefinitely between handovers; drawing_logic samples it on dir_valid or uses the level.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Per-button frame counter, width $clog2(REPEAT_FRAMES+1), cleared whenever btn_level[i]=0.
  - Counts frame_stb while btn_level[i]=1. On reaching REPEAT_FRAMES it injects a btn_press[i] pulse on the cycle after frame_stb and reloads to 0.
  - Injected pulses arbitrate exactly as real presses.
- Undefined: no repeat logic is synthesized; a held button yields exactly one btn_press.

Decomposition:
- params package, sub-package params::input:
  - dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3).
  - Button index constants BTN_U/BTN_D/BTN_L/BTN_R.
  - DEBOUNCE_CYCLES and REPEAT_FRAMES defaults.
- dir_t is shared with drawing_logic.
- Sub-module btn_debounce: single-bit synchronizer + debounce + edge detect, instantiated 4x. Arbitration, handover and auto-repeat stay in button_input_ctrl.

Test Plan (sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_FRAMES=2):
- Reset: hold rst_n=0 three cycles with btn_raw=4'b1111 -> btn_level=0, dir=DIR_RIGHT, pending=0, dir_valid=0.
- Debounce:
  - btn_raw[0]=1 for 3 cycles then 0 -> btn_level stays 0, no btn_press.
  - btn_raw[0]=1 held -> btn_level[0]=1 exactly 2+4 cycles after the change; btn_press[0] one cycle later; pending=1.
- Arbitration and handover:
  - btn_raw=4'b1010 rising together, then frame_stb -> winner D; dir=DIR_DOWN, dir_valid pulse, pending=0.
  - L pressed, then R pressed, then frame_stb -> dir=DIR_RIGHT.
- Same-cycle press and frame_stb:
  - btn_press[2] coincident with frame_stb, pending U -> dir=DIR_LEFT next cycle.
  - Press one cycle after frame_stb -> pending=1, dir unchanged until the next frame_stb.
- No-press frame and mid-operation reset:
  - frame_stb with no pending -> dir holds, dir_valid=0.
  - rst_n=0 while pending=1 -> pending=0; next frame_stb gives no dir_valid.
- BTN_AUTOREPEAT_EN:
  - Hold U across 5 frame_stb -> btn_press[0] once on the debounce edge, then after frames 2 and 4.
  - Without the macro -> exactly one btn_press.
